// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
//
// Write-domain control stage of an asynchronous FIFO. It keeps the binary
// write pointer, publishes its Gray-coded copy for the read-domain
// synchronizer, and derives registered full / almost_full / fill-level status
// from the read pointer that has already been synchronized into this domain.
// A sticky overflow flag records writes attempted while full.
//
// Ports
//   clk          in   write-domain clock
//   reset        in   asynchronous, active-high reset
//   wr_en        in   write request from producer
//   rd_ptr_sync  in   Gray read pointer, synchronized into clk domain
//   overflow_clr in   clears the sticky overflow flag
//   wr_fire      out  memory write enable (wr_en & ~full)
//   wr_addr      out  memory write address (low bits of binary pointer)
//   wr_ptr_gray  out  registered Gray write pointer
//   full         out  FIFO full, registered
//   almost_full  out  free slots <= ALMOST_FULL_THRESH, registered
//   wr_level     out  conservative occupancy 0..DEPTH, registered
//   overflow     out  sticky flag: write attempted while full
// -----------------------------------------------------------------------------
module fifo_wptr_full #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    input  logic                  overflow_clr,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_THRESH);

    logic [PW-1:0] wr_bin_q,      wr_bin_d;
    logic [PW-1:0] wr_gray_q,     wr_gray_d;
    logic          full_q,        full_d;
    logic          almost_full_q, almost_full_d;
    logic [PW-1:0] wr_level_q,    wr_level_d;
    logic          overflow_q,    overflow_d;

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_match;

    // Depends only on wr_en and the registered full flag, so the memory
    // write enable never sees the synchronized read pointer combinationally.
    assign wr_fire = wr_en & ~full_q;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
    // above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rd_bin[i] = ^(rd_ptr_sync >> i);
        end
    end

    // The write pointer is exactly one lap ahead of the read pointer when the
    // top two Gray bits are inverted and the rest match.
    assign full_match = {~rd_ptr_sync[PW-1:PW-2], rd_ptr_sync[PW-3:0]};

    always_comb begin
        wr_bin_d      = wr_bin_q + {{(PW-1){1'b0}}, wr_fire};
        wr_gray_d     = wr_bin_d ^ (wr_bin_d >> 1);
        full_d        = (wr_gray_d == full_match);
        wr_level_d    = wr_bin_d - rd_bin;
        almost_full_d = (wr_level_d >= AF_LEVEL);

        // Setting wins over clearing so a rejected write is never lost.
        overflow_d = overflow_q;
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bin_q      <= '0;
            wr_gray_q     <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wr_level_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_bin_q      <= wr_bin_d;
            wr_gray_q     <= wr_gray_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wr_level_q    <= wr_level_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_level    = wr_level_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full
//
// Directed bench for fifo_wptr_full (ADDR_WIDTH=4, ALMOST_FULL_THRESH=2).
// Walks reset, fill-to-full, overflow, release, simultaneous read/write and
// pointer wrap-around, checking each step against hand-derived values.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] rd_ptr_sync;
    logic       overflow_clr;
    logic       wr_fire;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    fifo_wptr_full #(
        .ADDR_WIDTH        (4),
        .ALMOST_FULL_THRESH(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .rd_ptr_sync (rd_ptr_sync),
        .overflow_clr(overflow_clr),
        .wr_fire     (wr_fire),
        .wr_addr     (wr_addr),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(wr_addr),     32'd0);
        chk({tag, "_gray"},  32'(wr_ptr_gray), 32'd0);
        chk({tag, "_full"},  32'(full),        32'd0);
        chk({tag, "_af"},    32'(almost_full), 32'd0);
        chk({tag, "_level"}, 32'(wr_level),    32'd0);
        chk({tag, "_ovf"},   32'(overflow),    32'd0);
    endtask

    logic [4:0] prev_gray;

    initial begin
        reset        = 1'b1;
        wr_en        = 1'b1;
        rd_ptr_sync  = 5'd0;
        overflow_clr = 1'b0;

        // Reset held from time zero
        #2;
        chk_all_zero("rst0");
        chk("rst0_fire", 32'(wr_fire), 32'd1);

        // Two writes, then asynchronous reset mid-cycle
        @(negedge clk);
        reset = 1'b0;
        edge_step();
        chk("pre_level1", 32'(wr_level),    32'd1);
        chk("pre_gray1",  32'(wr_ptr_gray), 32'd1);
        chk("pre_addr1",  32'(wr_addr),     32'd1);
        edge_step();
        chk("pre_level2", 32'(wr_level),    32'd2);
        chk("pre_gray2",  32'(wr_ptr_gray), 32'd3);
        reset = 1'b1;
        #1;
        chk_all_zero("rst1");
        chk("rst1_fire", 32'(wr_fire), 32'd1);
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Fill to full
        wr_en = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_addr", 32'(wr_addr), 32'(i));
            chk("fill_fire", 32'(wr_fire), 32'd1);
            edge_step();
            chk("fill_level", 32'(wr_level),    32'(i + 1));
            chk("fill_af",    32'(almost_full), 32'((i + 1) >= 14));
            chk("fill_full",  32'(full),        32'((i + 1) == 16));
        end
        chk("full_gray", 32'(wr_ptr_gray), 32'h18);
        chk("full_fire", 32'(wr_fire),     32'd0);

        // Overflow while full
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("ovf_gray",  32'(wr_ptr_gray), 32'h18);
            chk("ovf_flag",  32'(overflow),    32'd1);
            chk("ovf_full",  32'(full),        32'd1);
            chk("ovf_level", 32'(wr_level),    32'd16);
        end
        wr_en        = 1'b0;
        overflow_clr = 1'b1;
        edge_step();
        chk("ovf_clr",      32'(overflow), 32'd0);
        chk("ovf_clr_full", 32'(full),     32'd1);
        wr_en = 1'b1;
        edge_step();
        chk("ovf_set_wins", 32'(overflow),    32'd1);
        chk("ovf_set_gray", 32'(wr_ptr_gray), 32'h18);
        overflow_clr = 1'b0;

        // Release: read pointer advances to 1
        wr_en       = 1'b0;
        rd_ptr_sync = 5'b00001;
        edge_step();
        chk("rel_full",  32'(full),        32'd0);
        chk("rel_level", 32'(wr_level),    32'd15);
        chk("rel_af",    32'(almost_full), 32'd1);
        chk("rel_addr",  32'(wr_addr),     32'd0);
        chk("rel_ovf",   32'(overflow),    32'd1);

        // Simultaneous write and one-step read advance at level 15
        wr_en       = 1'b1;
        rd_ptr_sync = gray5(2);
        #1;
        chk("sim_fire", 32'(wr_fire), 32'd1);
        edge_step();
        chk("sim_level", 32'(wr_level),    32'd15);
        chk("sim_full",  32'(full),        32'd0);
        chk("sim_af",    32'(almost_full), 32'd1);
        chk("sim_gray",  32'(wr_ptr_gray), 32'(gray5(17)));
        chk("sim_addr",  32'(wr_addr),     32'd1);

        // Wrap-around with the read side two writes behind
        wr_en       = 1'b0;
        rd_ptr_sync = 5'd0;
        reset       = 1'b1;
        #1;
        chk_all_zero("rst2");
        reset = 1'b0;
        wr_en = 1'b1;
        edge_step();
        edge_step();
        chk("wrap_pre_level", 32'(wr_level), 32'd2);
        for (int n = 2; n < 42; n++) begin
            rd_ptr_sync = gray5(n - 2);
            #1;
            chk("wrap_addr", 32'(wr_addr), 32'(n & 15));
            prev_gray = wr_ptr_gray;
            edge_step();
            chk("wrap_gray",    32'(wr_ptr_gray), 32'(gray5(n + 1)));
            chk("wrap_onebit",  32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
            chk("wrap_full",    32'(full),     32'd0);
            chk("wrap_level",   32'(wr_level), 32'(((n + 1) - (n - 2)) & 31));
        end
        chk("wrap_final_addr", 32'(wr_addr), 32'(42 & 15));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
